// File: rtl/conv_scheduler_if.sv
// Handshake/status bundle between the conv scheduler, the double-buffer
// write side, the read address generators and the systolic array.
interface conv_scheduler_if #(
    parameter int FIELD_WIDTH = 8
);
    logic                       config_enable;
    logic [6*FIELD_WIDTH-1:0]   config_data;
    logic                       start;
    logic                       stall;
    logic                       weight_bank_ready;
    logic                       input_bank_ready;
    logic                       weight_ren;
    logic                       weight_write_enable_arr;
    logic                       input_ren;
    logic                       sys_arr_enable;
    logic                       tile_last;
    logic                       bank_release;
    logic                       done;
    logic                       busy;
    logic                       cfg_err;

    modport master (
        output config_enable, config_data, start, stall,
               weight_bank_ready, input_bank_ready,
        input  weight_ren, weight_write_enable_arr, input_ren, sys_arr_enable,
               tile_last, bank_release, done, busy, cfg_err
    );

    modport slave (
        input  config_enable, config_data, start, stall,
               weight_bank_ready, input_bank_ready,
        output weight_ren, weight_write_enable_arr, input_ren, sys_arr_enable,
               tile_last, bank_release, done, busy, cfg_err
    );
endinterface

// File: rtl/conv_scheduler.sv
// Conv loop-nest controller: per tile, loads weights, streams ifmap rows and
// drains partial sums, walking the fx/fy/ic1/oc1 tile nest.
module conv_scheduler #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int FIELD_WIDTH  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    conv_scheduler_if.slave bus
);
    localparam int CW = 2 * FIELD_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam logic [CW-1:0]          LOAD_LAST  = CW'(ARRAY_HEIGHT - 1);
    localparam logic [CW-1:0]          DRAIN_LAST = CW'(ARRAY_HEIGHT + ARRAY_WIDTH - 2);
    localparam logic [CW-1:0]          C_ONE      = CW'(1);
    localparam logic [FIELD_WIDTH-1:0] F_ONE      = FIELD_WIDTH'(1);

    logic [2:0]             state;
    logic [CW-1:0]          cyc_cnt;
    logic [CW-1:0]          stream_last;
    logic [CW-1:0]          phase_last;
    logic [FIELD_WIDTH-1:0] fx_cnt, fy_cnt, ic_cnt, oc_cnt;
    logic [FIELD_WIDTH-1:0] fx_max, fy_max, ic_max, oc_max;
    logic [FIELD_WIDTH-1:0] f_ox, f_oy, f_fx, f_fy, f_ic, f_oc;
    logic                   cfg_valid;
    logic                   fields_ok;
    logic                   advance;
    logic                   phase_done;
    logic                   inner_max;
    logic                   layer_end;
    logic                   weight_ren;
    logic                   input_ren;
    logic                   wwe_q, sae_q, done_q, brel_q, err_q;

    assign f_ox = bus.config_data[0*FIELD_WIDTH +: FIELD_WIDTH];
    assign f_oy = bus.config_data[1*FIELD_WIDTH +: FIELD_WIDTH];
    assign f_fx = bus.config_data[2*FIELD_WIDTH +: FIELD_WIDTH];
    assign f_fy = bus.config_data[3*FIELD_WIDTH +: FIELD_WIDTH];
    assign f_ic = bus.config_data[4*FIELD_WIDTH +: FIELD_WIDTH];
    assign f_oc = bus.config_data[5*FIELD_WIDTH +: FIELD_WIDTH];

    assign fields_ok = (f_ox != '0) && (f_oy != '0) && (f_fx != '0) &&
                       (f_fy != '0) && (f_ic != '0) && (f_oc != '0);

    assign advance = ((state == S_LOAD) || (state == S_STREAM) || (state == S_DRAIN)) && !bus.stall;

    always_comb begin
        phase_last = LOAD_LAST;
        case (state)
            S_STREAM: phase_last = stream_last;
            S_DRAIN:  phase_last = DRAIN_LAST;
            default:  phase_last = LOAD_LAST;
        endcase
    end

    assign phase_done = (cyc_cnt == phase_last);
    assign inner_max  = (fx_cnt == fx_max) && (fy_cnt == fy_max) && (ic_cnt == ic_max);
    assign layer_end  = (state == S_DRAIN) && advance && phase_done && inner_max && (oc_cnt == oc_max);

    assign weight_ren = (state == S_LOAD) && !bus.stall;
    assign input_ren  = (state == S_STREAM) && !bus.stall;

    assign bus.weight_ren              = weight_ren;
    assign bus.input_ren               = input_ren;
    assign bus.weight_write_enable_arr = wwe_q;
    assign bus.sys_arr_enable          = sae_q;
    assign bus.tile_last               = ((state == S_STREAM) || (state == S_DRAIN)) && inner_max;
    assign bus.bank_release            = brel_q;
    assign bus.done                    = done_q;
    assign bus.busy                    = (state != S_IDLE);
    assign bus.cfg_err                 = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            stream_last <= '0;
            fx_cnt      <= '0;
            fy_cnt      <= '0;
            ic_cnt      <= '0;
            oc_cnt      <= '0;
            fx_max      <= '0;
            fy_max      <= '0;
            ic_max      <= '0;
            oc_max      <= '0;
            cfg_valid   <= 1'b0;
            wwe_q       <= 1'b0;
            sae_q       <= 1'b0;
            done_q      <= 1'b0;
            brel_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wwe_q  <= weight_ren;
            sae_q  <= ((state == S_STREAM) || (state == S_DRAIN)) && !bus.stall;
            done_q <= layer_end;
            brel_q <= layer_end;
            err_q  <= bus.config_enable && ((state != S_IDLE) || !fields_ok);

            // Bounds are kept as max values so every wrap test is a plain compare.
            if (bus.config_enable && (state == S_IDLE) && fields_ok) begin
                stream_last <= CW'(f_ox) * CW'(f_oy) - C_ONE;
                fx_max      <= f_fx - F_ONE;
                fy_max      <= f_fy - F_ONE;
                ic_max      <= f_ic - F_ONE;
                oc_max      <= f_oc - F_ONE;
                cfg_valid   <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start && cfg_valid && !bus.config_enable)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.weight_bank_ready && bus.input_bank_ready) begin
                        state   <= S_LOAD;
                        cyc_cnt <= '0;
                    end
                end
                S_LOAD, S_STREAM: begin
                    if (advance) begin
                        if (phase_done) begin
                            state   <= (state == S_LOAD) ? S_STREAM : S_DRAIN;
                            cyc_cnt <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + C_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (advance) begin
                        if (phase_done) begin
                            cyc_cnt <= '0;
                            state   <= layer_end ? S_IDLE : S_LOAD;
                            // At layer end every counter is at max, so the nest wraps to all-zero.
                            if (fx_cnt != fx_max) begin
                                fx_cnt <= fx_cnt + F_ONE;
                            end else begin
                                fx_cnt <= '0;
                                if (fy_cnt != fy_max) begin
                                    fy_cnt <= fy_cnt + F_ONE;
                                end else begin
                                    fy_cnt <= '0;
                                    if (ic_cnt != ic_max) begin
                                        ic_cnt <= ic_cnt + F_ONE;
                                    end else begin
                                        ic_cnt <= '0;
                                        oc_cnt <= (oc_cnt == oc_max) ? '0 : oc_cnt + F_ONE;
                                    end
                                end
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + C_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: tile-progress reference model checked every cycle,
// directed scenarios with hand-computed totals, then randomized layers.
module tb_conv_scheduler;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int FW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_scheduler_if #(.FIELD_WIDTH(FW)) bus ();

    conv_scheduler #(
        .ARRAY_HEIGHT(H),
        .ARRAY_WIDTH(W),
        .FIELD_WIDTH(FW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6*FW-1:0] pack(input int ox, oy, fx, fy, ic, oc);
        return {FW'(oc), FW'(ic), FW'(fy), FW'(fx), FW'(oy), FW'(ox)};
    endfunction

    // Reference model: a layer is a flat run of progress steps; phase and
    // tile_last follow from the step index by division.
    int m_mode = 0;
    int m_p = 0;
    int m_L = 1;
    int m_total = 1;
    int m_ox = 1, m_oy = 1, m_fx = 1, m_fy = 1, m_ic = 1, m_oc = 1;
    bit m_valid = 0;
    bit e_wwe = 0, e_sae = 0, e_done = 0, e_err = 0;

    always @(negedge clk) begin : model_cmp
        int off, tile, per, ph;
        int f [6];
        bit run, x_wren, x_iren, x_tl, x_busy, nd, ok;
        run  = rst_n && (m_mode == 2);
        ph   = 0;
        x_tl = 0;
        if (run) begin
            off  = m_p % m_L;
            tile = m_p / m_L;
            per  = m_fx * m_fy * m_ic;
            ph   = (off < H) ? 0 : ((off < H + m_ox * m_oy) ? 1 : 2);
            x_tl = (ph != 0) && ((tile % per) == per - 1);
        end
        x_wren = run && (ph == 0) && !bus.stall;
        x_iren = run && (ph == 1) && !bus.stall;
        x_busy = rst_n && (m_mode != 0);
        if (!rst_n) begin
            e_wwe = 0; e_sae = 0; e_done = 0; e_err = 0;
        end
        check("weight_ren", bus.weight_ren, x_wren);
        check("input_ren", bus.input_ren, x_iren);
        check("tile_last", bus.tile_last, x_tl);
        check("busy", bus.busy, x_busy);
        check("weight_write_enable_arr", bus.weight_write_enable_arr, e_wwe);
        check("sys_arr_enable", bus.sys_arr_enable, e_sae);
        check("done", bus.done, e_done);
        check("bank_release", bus.bank_release, e_done);
        check("cfg_err", bus.cfg_err, e_err);
        if (rst_n) begin
            for (int k = 0; k < 6; k++) f[k] = int'(bus.config_data[k*FW +: FW]);
            ok = 1;
            for (int k = 0; k < 6; k++) if (f[k] == 0) ok = 0;
            nd = 0;
            e_err = bus.config_enable && ((m_mode != 0) || !ok);
            if (bus.config_enable && (m_mode == 0) && ok) begin
                m_ox = f[0]; m_oy = f[1]; m_fx = f[2]; m_fy = f[3]; m_ic = f[4]; m_oc = f[5];
                m_L = H + m_ox * m_oy + H + W - 1;
                m_total = m_L * m_fx * m_fy * m_ic * m_oc;
                m_valid = 1;
            end else if (m_mode == 0) begin
                if (bus.start && m_valid && !bus.config_enable) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.weight_bank_ready && bus.input_bank_ready) begin
                    m_mode = 2;
                    m_p = 0;
                end
            end else if (!bus.stall) begin
                m_p++;
                if (m_p == m_total) begin
                    m_mode = 0;
                    nd = 1;
                end
            end
            e_wwe  = x_wren;
            e_sae  = run && (ph != 0) && !bus.stall;
            e_done = nd;
        end else begin
            m_mode = 0; m_p = 0; m_valid = 0;
        end
    end

    int cyc = 0;
    int wren_cnt, iren_cnt, tl_cnt, tl_rises, first_wren, done_cyc;
    int brel_cnt, brel_cyc, err_cnt, busy_cnt;
    int tl_rise [8];
    bit tl_prev;

    task automatic clr_stats();
        wren_cnt = 0; iren_cnt = 0; tl_cnt = 0; tl_rises = 0; first_wren = -1;
        done_cyc = -1; brel_cnt = 0; brel_cyc = -1; err_cnt = 0; busy_cnt = 0;
        tl_prev = 0;
    endtask

    // Observe the current cycle mid-period, then move to just after the next edge.
    task automatic cycle();
        @(negedge clk);
        #1;
        cyc++;
        if (bus.weight_ren) begin
            wren_cnt++;
            if (first_wren < 0) first_wren = cyc;
        end
        if (bus.input_ren) iren_cnt++;
        if (bus.tile_last) begin
            tl_cnt++;
            if (!tl_prev && tl_rises < 8) begin
                tl_rise[tl_rises] = cyc;
                tl_rises++;
            end
        end
        tl_prev = bus.tile_last;
        if (bus.done && done_cyc < 0) done_cyc = cyc;
        if (bus.bank_release) begin
            brel_cnt++;
            if (brel_cyc < 0) brel_cyc = cyc;
        end
        if (bus.cfg_err) err_cnt++;
        if (bus.busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit && done_cyc < 0; i++) cycle();
        check({name, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    endtask

    task automatic write_cfg(input logic [6*FW-1:0] d);
        bus.config_data = d;
        bus.config_enable = 1'b1;
        cycle();
        bus.config_enable = 1'b0;
    endtask

    logic [6*FW-1:0] basic_cfg;
    int s, r, tiles, rox, roy;

    initial begin
        bus.config_enable = 0; bus.config_data = '0; bus.start = 0; bus.stall = 0;
        bus.weight_bank_ready = 1; bus.input_bank_ready = 1;
        basic_cfg = pack(3, 3, 3, 3, 2, 4);
        clr_stats();

        rst_n = 0;
        repeat (3) cycle();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst_n = 1;
        cycle();

        // Rejected config (oy0 = 0) and an ignored start.
        clr_stats();
        write_cfg(pack(3, 0, 3, 3, 2, 4));
        bus.start = 1;
        cycle();
        bus.start = 0;
        repeat (5) cycle();
        check("badcfg_err_pulses", err_cnt, 1);
        check("badcfg_start_ignored", busy_cnt, 0);

        // Basic layer with a config attempt while busy.
        write_cfg(basic_cfg);
        clr_stats();
        bus.start = 1;
        cycle();
        s = cyc;
        bus.start = 0;
        for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
            bus.config_enable = (i == 100);
            bus.config_data = (i == 100) ? pack(1, 1, 1, 1, 1, 1) : basic_cfg;
            cycle();
        end
        bus.config_enable = 0;
        bus.config_data = basic_cfg;
        check("basic_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
        check("basic_start_to_wren", first_wren - s, 2);
        check("basic_wren_to_done", done_cyc - first_wren, 1440);
        check("basic_wren_count", wren_cnt, 288);
        check("basic_iren_count", iren_cnt, 648);
        check("basic_busy_cfg_err", err_cnt, 1);
        check("basic_tile_last_rises", tl_rises, 4);
        check("basic_tile_last_cycles", tl_cnt, 64);
        for (int k = 0; k < 4; k++)
            check($sformatf("basic_tile_last_rise%0d", k), tl_rise[k] - first_wren, ((k + 1) * 18 - 1) * 20 + 4);
        check("basic_brel_with_done", brel_cyc, done_cyc);
        check("basic_brel_count", brel_cnt, 1);

        // Bank gating.
        clr_stats();
        bus.input_bank_ready = 0;
        bus.start = 1;
        cycle();
        bus.start = 0;
        repeat (50) cycle();
        check("gate_no_wren", wren_cnt, 0);
        check("gate_busy_waiting", busy_cnt, 50);
        bus.input_bank_ready = 1;
        cycle();
        r = cyc;
        wait_done("gate", 2000);
        check("gate_rise_to_wren", first_wren - r, 1);
        check("gate_wren_to_done", done_cyc - first_wren, 1440);

        // Five-cycle stall inside the first STREAM phase.
        clr_stats();
        bus.start = 1;
        cycle();
        bus.start = 0;
        for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
            bus.stall = (first_wren >= 0) && (cyc + 1 - first_wren >= 7) && (cyc + 1 - first_wren <= 11);
            cycle();
        end
        bus.stall = 0;
        check("stall_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
        check("stall_wren_to_done", done_cyc - first_wren, 1445);
        check("stall_iren_count", iren_cnt, 648);
        check("stall_wren_count", wren_cnt, 288);

        // Asynchronous reset during DRAIN of tile 10.
        clr_stats();
        bus.start = 1;
        cycle();
        bus.start = 0;
        for (int i = 0; i < 2000; i++) begin
            if (first_wren >= 0 && (cyc + 1 - first_wren) == 9 * 20 + 15) break;
            cycle();
        end
        check("rst_reached_drain", bus.busy, 1);
        rst_n = 0;
        #1;
        check("rst_async_busy", bus.busy, 0);
        check("rst_async_tile_last", bus.tile_last, 0);
        check("rst_async_sae", bus.sys_arr_enable, 0);
        check("rst_async_wwe", bus.weight_write_enable_arr, 0);
        cycle();
        cycle();
        check("rst_no_done", (done_cyc >= 0) ? 1 : 0, 0);
        clr_stats();
        rst_n = 1;
        bus.start = 1;
        cycle();
        bus.start = 0;
        repeat (10) cycle();
        check("rst_start_ignored", busy_cnt, 0);

        // Minimal layer.
        write_cfg(pack(1, 1, 1, 1, 1, 1));
        clr_stats();
        bus.start = 1;
        cycle();
        bus.start = 0;
        wait_done("min", 100);
        check("min_wren_to_done", done_cyc - first_wren, 12);
        check("min_wren_count", wren_cnt, 4);
        check("min_iren_count", iren_cnt, 1);
        check("min_tile_last_cycles", tl_cnt, 8);
        check("min_brel_with_done", brel_cyc, done_cyc);

        // Randomized layers with stalls, bank gaps and spurious config writes.
        for (int L = 0; L < 6; L++) begin
            rox = $urandom_range(1, 3);
            roy = $urandom_range(1, 3);
            tiles = 1;
            bus.config_data = pack(rox, roy, 1, 1, 1, 1);
            for (int k = 2; k < 6; k++) begin
                int v;
                v = $urandom_range(1, 2);
                tiles = tiles * v;
                bus.config_data[k*FW +: FW] = FW'(v);
            end
            write_cfg(bus.config_data);
            clr_stats();
            bus.start = 1;
            cycle();
            bus.start = 0;
            for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
                bus.stall = ($urandom_range(0, 7) == 0);
                bus.weight_bank_ready = ($urandom_range(0, 3) != 0);
                bus.input_bank_ready = ($urandom_range(0, 3) != 0);
                bus.config_enable = ($urandom_range(0, 63) == 0);
                if (bus.config_enable)
                    bus.config_data = pack($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                cycle();
            end
            bus.stall = 0; bus.config_enable = 0;
            bus.weight_bank_ready = 1; bus.input_bank_ready = 1;
            check("rand_done_seen", (done_cyc >= 0) ? 1 : 0, 1);
            check("rand_wren_count", wren_cnt, H * tiles);
            check("rand_iren_count", iren_cnt, rox * roy * tiles);
        end

        repeat (3) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
